// File: rtl/nfu_pkg.sv
// Shared widths, op encoding and controller state for the NBout partial-sum path.
package nfu_pkg;
  localparam int unsigned N      = 16;
  localparam int unsigned Tn     = 16;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PASS_W = 8;
  localparam int unsigned ROW_W  = N * Tn;

  localparam logic OP_SUM = 1'b0;
  localparam logic OP_MAX = 1'b1;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/nbout_psum_ctrl_if.sv
// Control/data bundle between NFU-1/NFU-2/NFU-3 and the partial-sum controller.
interface nbout_psum_ctrl_if import nfu_pkg::*; ();
  logic              i_start;
  logic [ADDR_W-1:0] i_rows_m1;
  logic [PASS_W-1:0] i_passes_m1;
  logic              i_op;
  logic              i_nfu1_valid;
  row_t              i_nfu2_out;
  logic              o_op;
  row_t              o_nbout;
  row_t              o_out;
  logic              o_out_valid;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start, i_rows_m1, i_passes_m1, i_op, i_nfu1_valid, i_nfu2_out,
    input  o_op, o_nbout, o_out, o_out_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_rows_m1, i_passes_m1, i_op, i_nfu1_valid, i_nfu2_out,
    output o_op, o_nbout, o_out, o_out_valid, o_busy, o_done
  );
endinterface

// File: rtl/nbout_ram.sv
// Partial-sum row store: one synchronous read port, one write port, no RAW handling.
module nbout_ram import nfu_pkg::*; (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  row_t              wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output row_t              rdata
);
  row_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/nbout_psum_ctrl.sv
// NBout partial-sum controller: read/modify/write of rows across accumulation passes,
// with pass-0 zero injection, same-row bypass and final-pass forwarding to NFU-3.
module nbout_psum_ctrl import nfu_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  nbout_psum_ctrl_if.slave  bus
);
  state_e            state;
  logic [ADDR_W-1:0] rows_m1_q;
  logic [ADDR_W-1:0] row_q;
  logic [PASS_W-1:0] passes_m1_q;
  logic [PASS_W-1:0] pass_q;
  logic              flush_cnt;

  logic              s2_valid;
  logic [ADDR_W-1:0] s2_addr;
  logic              s2_zero;
  logic              s2_byp;
  logic              s2_last_pass;
  logic              s2_final;
  row_t              byp_data;
  row_t              ram_rdata;

  logic fire_c;
  logic row_wrap_c;
  logic tile_end_c;
  logic raw_c;

  assign fire_c     = (state == RUN) && bus.i_nfu1_valid;
  assign row_wrap_c = (row_q == rows_m1_q);
  assign tile_end_c = fire_c && row_wrap_c && (pass_q == passes_m1_q);
  // Stage-1 read hits the row stage 2 is writing this very cycle.
  assign raw_c      = fire_c && s2_valid && (s2_addr == row_q);

  nbout_ram u_ram (
    .clk   (clk),
    .we    (s2_valid),
    .waddr (s2_addr),
    .wdata (bus.i_nfu2_out),
    .re    (fire_c),
    .raddr (row_q),
    .rdata (ram_rdata)
  );

  // Select regs only change on a stage-1 read, so o_nbout holds through gaps.
  assign bus.o_nbout = s2_zero ? '0 : (s2_byp ? byp_data : ram_rdata);

  // Tile sequencing: counters, latched config, busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rows_m1_q   <= '0;
      passes_m1_q <= '0;
      row_q       <= '0;
      pass_q      <= '0;
      flush_cnt   <= 1'b0;
      bus.o_op    <= 1'b0;
      bus.o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state       <= RUN;
            rows_m1_q   <= bus.i_rows_m1;
            passes_m1_q <= bus.i_passes_m1;
            bus.o_op    <= bus.i_op;
            row_q       <= '0;
            pass_q      <= '0;
            bus.o_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (fire_c) begin
            if (row_wrap_c) begin
              row_q  <= '0;
              pass_q <= pass_q + PASS_W'(1);
            end else begin
              row_q  <= row_q + ADDR_W'(1);
            end
            if (tile_end_c) begin
              state     <= FLUSH;
              flush_cnt <= 1'b0;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 2 bookkeeping and stage-3 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid        <= 1'b0;
      s2_addr         <= '0;
      s2_zero         <= 1'b1;
      s2_byp          <= 1'b0;
      s2_last_pass    <= 1'b0;
      s2_final        <= 1'b0;
      byp_data        <= '0;
      bus.o_out       <= '0;
      bus.o_out_valid <= 1'b0;
      bus.o_done      <= 1'b0;
    end else begin
      s2_valid <= fire_c;
      if (fire_c) begin
        s2_addr      <= row_q;
        s2_zero      <= (pass_q == '0);
        s2_byp       <= raw_c;
        s2_last_pass <= (pass_q == passes_m1_q);
        s2_final     <= tile_end_c;
      end
      if (raw_c) byp_data <= bus.i_nfu2_out;
      bus.o_out_valid <= s2_valid && s2_last_pass;
      bus.o_done      <= s2_valid && s2_final;
      if (s2_valid && s2_last_pass) bus.o_out <= bus.i_nfu2_out;
    end
  end
endmodule
